// File: rtl/stream_bist_harness.sv
// Stream BIST harness: a memory-backed AXI4-Stream-style source and a golden-compare sink with LFSR throttling.
// Optional feature: define STREAM_BIST_LAST_CHECK_EN to also check s_last on every sink beat.
module stream_bist_harness #(
  parameter int          IN_W      = 8,
  parameter int          OUT_W     = 16,
  parameter int          IN_LEN    = 2048,
  parameter int          OUT_LEN   = 1536,
  parameter int          AW        = 12,
  parameter int          TO_W      = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             throttle_en,
  input  logic [TO_W-1:0]  timeout_lim,
  output logic [AW-1:0]    in_mem_addr,
  input  logic [IN_W-1:0]  in_mem_rdata,
  output logic [AW-1:0]    gold_addr,
  input  logic [OUT_W-1:0] gold_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [IN_W-1:0]  m_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  input  logic [OUT_W-1:0] s_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [AW-1:0]    err_cnt,
  output logic [AW-1:0]    first_err_idx
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   rd_cnt;      // next input address to fetch
  logic [AW-1:0]   snt_cnt;     // source beats accepted by the DUT
  logic [AW-1:0]   out_cnt;     // sink beats accepted from the DUT
  logic [1:0]      cnt;         // prefetch buffer occupancy
  logic            head;
  logic            pend;        // a read was issued last cycle; its data is on in_mem_rdata now
  logic            m_hold;      // m_valid was shown and not taken; it must stay up
  logic [IN_W-1:0] fifo_q [2];
  logic [15:0]     lfsr;
  logic [TO_W-1:0] to_cnt;

  logic       run_st;
  logic       src_fire;
  logic       snk_fire;
  logic       issue;
  logic [2:0] occ;
  logic       last_beat;
  logic       beat_err;
  logic       to_hit;

  assign run_st = (state == RUN);
  assign busy   = (state == PRIME) || run_st;
  assign done   = (state == DONE);
  assign pass   = done & ~timeout & (err_cnt == '0);

  // Source: m_valid may only be throttled before it is presented.
  assign m_valid  = run_st & (cnt != 2'd0) & (m_hold | ~(throttle_en & lfsr[0]));
  assign m_data   = fifo_q[head];
  assign m_last   = m_valid & (snt_cnt == AW'(IN_LEN - 1));
  assign src_fire = m_valid & m_ready;

  // Fetch whenever the slot the read lands in next cycle is guaranteed free.
  assign occ         = {1'b0, cnt} + {2'b00, pend};
  assign issue       = busy & (rd_cnt < AW'(IN_LEN)) & (occ <= ({2'b00, src_fire} + 3'd1));
  assign in_mem_addr = rd_cnt;

  // Sink: look one beat ahead on fire so gold_rdata always matches out_cnt.
  assign s_ready   = run_st & (out_cnt < AW'(OUT_LEN)) & ~(throttle_en & lfsr[1]);
  assign snk_fire  = s_valid & s_ready;
  assign gold_addr = out_cnt + {{(AW-1){1'b0}}, snk_fire};
  assign last_beat = (out_cnt == AW'(OUT_LEN - 1));

`ifdef STREAM_BIST_LAST_CHECK_EN
  assign beat_err = (s_data != gold_rdata) | (s_last != last_beat);
`else
  assign beat_err = (s_data != gold_rdata);
`endif

  assign to_hit = (timeout_lim != '0) & (to_cnt == timeout_lim - TO_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rd_cnt        <= '0;
      snt_cnt       <= '0;
      out_cnt       <= '0;
      cnt           <= '0;
      head          <= 1'b0;
      pend          <= 1'b0;
      m_hold        <= 1'b0;
      // NOTE: the two buffer entries are reset because m_data must read 0 out of reset.
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      lfsr          <= LFSR_SEED;
      to_cnt        <= '0;
      timeout       <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '1;
    end else begin
      if (pend) fifo_q[head ^ cnt[0]] <= in_mem_rdata;
      cnt    <= cnt + {1'b0, pend} - {1'b0, src_fire};
      pend   <= issue;
      m_hold <= m_valid & ~m_ready;
      if (issue) rd_cnt <= rd_cnt + AW'(1);
      if (src_fire) begin
        head    <= ~head;
        snt_cnt <= snt_cnt + AW'(1);
      end
      if (run_st) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

      // NOTE: non-blocking assignments below deliberately override the datapath updates above;
      // the last assignment to a register in the block wins.
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= PRIME;
            rd_cnt        <= '0;
            snt_cnt       <= '0;
            out_cnt       <= '0;
            cnt           <= '0;
            head          <= 1'b0;
            pend          <= 1'b0;
            m_hold        <= 1'b0;
            to_cnt        <= '0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '1;
          end
        end
        PRIME: state <= RUN;
        RUN: begin
          if (snk_fire) begin
            out_cnt <= out_cnt + AW'(1);
            to_cnt  <= '0;
            if (beat_err) begin
              if (err_cnt != '1)        err_cnt       <= err_cnt + AW'(1);
              if (first_err_idx == '1)  first_err_idx <= out_cnt;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
          // Completion needs a fire, which also clears the timeout, so completion wins a tie.
          if (snk_fire && last_beat) begin
            state <= DONE;
          end else if (!snk_fire && to_hit) begin
            state   <= DONE;
            timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
